// File: rtl/pos_sweep_checker.sv
// Exhaustive sweep of a 5-input combinational cell: drives every vector, captures F
// into a truth table, then reports ones count, pass and the first mismatching index.
module pos_sweep_checker #(
  parameter int unsigned        N_IN       = 5,
  parameter int unsigned        SETTLE_CYC = 1,
  parameter logic [2**N_IN-1:0] EXP_TT     = 32'hCC4C_F05F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        ones_cnt,
  output logic                 pass,
  output logic [N_IN-1:0]      first_mm_idx
);

  localparam int unsigned TT_W  = 2**N_IN;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   mm_q, mm_d;

  function automatic logic [N_IN-1:0] lowest_set(input logic [TT_W-1:0] v);
    logic [N_IN-1:0] r;
    r = '0;
    for (int unsigned i = TT_W; i > 0; i--) begin
      if (v[i-1]) r = N_IN'(i - 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      dut_in_q <= '0;
      cnt_q    <= '0;
      tt_q     <= '0;
      ones_q   <= '0;
      pass_q   <= 1'b0;
      mm_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      tt_q     <= tt_d;
      ones_q   <= ones_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    tt_d     = tt_q;
    ones_d   = ones_q;
    pass_d   = pass_q;
    mm_d     = mm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tt_d     = '0;
          ones_d   = '0;
          mm_d     = '0;
          idx_d    = '0;
          dut_in_d = '0;
          cnt_d    = CNT_W'(SETTLE_CYC);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      SAMPLE: begin
        tt_d[idx_q] = dut_f;
        ones_d      = ones_q + {{N_IN{1'b0}}, dut_f};
        // Verdict is taken from the table including the final sample so it is valid while done is high
        if (idx_q == '1) begin
          pass_d  = (tt_d == EXP_TT);
          mm_d    = lowest_set(tt_d ^ EXP_TT);
          state_d = DONE;
        end else begin
          idx_d    = idx_q + N_IN'(1);
          dut_in_d = idx_q + N_IN'(1);
          cnt_d    = CNT_W'(SETTLE_CYC);
          state_d  = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dut_in       = dut_in_q;
  assign busy         = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done         = (state_q == DONE);
  assign tt           = tt_q;
  assign ones_cnt     = ones_q;
  assign pass         = pass_q;
  assign first_mm_idx = mm_q;

endmodule

// File: tb/tb_pos_sweep_checker.sv
// Bench for pos_sweep_checker: table-driven cell model, directed and randomized sweeps
// checked against expectations derived from the truth table with plain arithmetic.
module tb_pos_sweep_checker;

  localparam logic [31:0] EXP = 32'hCC4C_F05F;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [31:0] cur_tbl;

  logic [4:0]  a_in, b_in;
  logic        a_f, b_f;
  logic        a_busy, b_busy, a_done, b_done, a_pass, b_pass;
  logic [31:0] a_tt, b_tt;
  logic [5:0]  a_ones, b_ones;
  logic [4:0]  a_mm, b_mm;

  assign a_f = cur_tbl[a_in];
  assign b_f = cur_tbl[b_in];

  pos_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(a_in), .dut_f(a_f),
    .busy(a_busy), .done(a_done), .tt(a_tt), .ones_cnt(a_ones), .pass(a_pass),
    .first_mm_idx(a_mm)
  );

  pos_sweep_checker #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(b_in), .dut_f(b_f),
    .busy(b_busy), .done(b_done), .tt(b_tt), .ones_cnt(b_ones), .pass(b_pass),
    .first_mm_idx(b_mm)
  );

  int sel = 0;
  logic [4:0]  o_in, o_mm;
  logic        o_busy, o_done, o_pass;
  logic [31:0] o_tt;
  logic [5:0]  o_ones;

  always_comb begin
    o_in   = (sel != 0) ? b_in   : a_in;
    o_busy = (sel != 0) ? b_busy : a_busy;
    o_done = (sel != 0) ? b_done : a_done;
    o_tt   = (sel != 0) ? b_tt   : a_tt;
    o_ones = (sel != 0) ? b_ones : a_ones;
    o_pass = (sel != 0) ? b_pass : a_pass;
    o_mm   = (sel != 0) ? b_mm   : a_mm;
  end

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start_b = v;
    else          start_a = v;
  endtask

  function automatic int exp_mm(input logic [31:0] tbl);
    logic [31:0] diff;
    diff = tbl ^ EXP;
    for (int i = 0; i < 32; i++) if (diff[i]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] all_outs();
    return {13'd0, o_in, o_busy, o_done, o_tt, o_ones, o_pass, o_mm};
  endfunction

  task automatic check_results(input string tag);
    chk({tag, "_tt"},   o_tt,   cur_tbl);
    chk({tag, "_ones"}, o_ones, $countones(cur_tbl));
    chk({tag, "_pass"}, o_pass, (cur_tbl == EXP));
    chk({tag, "_mm"},   o_mm,   exp_mm(cur_tbl));
  endtask

  // Cycle c is the interval following edge c-1; the start is accepted at edge 0.
  task automatic sweep(input int s, input int extra_at, input int abort_at);
    int period, done_c, exp_in;
    period = s + 1;
    done_c = 32 * period + 1;
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1; set_start(1'b0);
    for (int c = 1; c <= done_c + 3; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_async_outs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_outs", all_outs(), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      exp_in = (c - 1) / period;
      if (exp_in > 31) exp_in = 31;
      chk("dut_in", o_in, exp_in);
      chk("busy", o_busy, (c < done_c));
      chk("done", o_done, (c == done_c));
      if (c == done_c) check_results("res");
      if (c == extra_at)          set_start(1'b1);
      else if (c == extra_at + 1) set_start(1'b0);
      @(posedge clk); #1;
    end
    check_results("hold");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, first_c, second_c;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    cur_tbl = EXP;
    repeat (3) @(posedge clk);
    #1;
    sel = 0; #1; chk("reset_dut", all_outs(), 64'd0);
    sel = 1; #1; chk("reset_dut3", all_outs(), 64'd0);
    sel = 0;
    @(negedge clk); rst_n = 1'b1;

    cur_tbl = EXP;                 sweep(1, -1, -1);
    cur_tbl = 32'h0;               sweep(1, -1, -1);
    cur_tbl = EXP | 32'h0000_0020; sweep(1, -1, -1);
    cur_tbl = EXP;                 sweep(1, 10, -1);
    cur_tbl = EXP;                 sweep(1, -1, 20);
    cur_tbl = EXP;                 sweep(1, -1, -1);

    sel = 1;
    cur_tbl = EXP;                 sweep(3, -1, -1);
    sel = 0;

    for (int k = 0; k < 3; k++) begin
      cur_tbl = $urandom;
      sweep(1, -1, -1);
    end
    cur_tbl = EXP ^ (32'h1 << $urandom_range(31, 0));
    sweep(1, -1, -1);

    // start held high across the return to IDLE launches back-to-back sweeps
    cur_tbl = EXP;
    nd = 0; first_c = 0; second_c = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 140; c++) begin
      if (a_done) begin
        nd++;
        if (nd == 1) first_c = c;
        else if (nd == 2) second_c = c;
      end
      if (c == 70) start_a = 1'b0;
      @(posedge clk); #1;
    end
    chk("held_start_done_count", nd, 2);
    chk("held_start_first_done", first_c, 65);
    chk("held_start_second_done", second_c, 131);
    check_results("held_start");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
